// File: rtl/rtype_encoder.sv
// RV64 R-type instruction encoder: op/rs1/rs2/rd in, 32-bit word out through
// a 2-entry FIFO with valid/ready handshakes on both sides.
module rtype_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] enc_count
);

  logic [31:0] r_mem [2];
  logic        r_head;
  logic [1:0]  r_count;
  logic        r_err;
  logic [15:0] r_enc_count;

  logic        w_legal;
  logic [6:0]  w_funct7;
  logic [2:0]  w_funct3;
  logic [6:0]  w_opcode;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_ptr;

  always_comb begin
    w_legal  = 1'b1;
    w_funct7 = 7'h00;
    w_funct3 = 3'b000;
    w_opcode = 7'h33;
    case (op)
      5'd0:  w_funct3 = 3'b000;
      5'd1:  begin w_funct7 = 7'h20; w_funct3 = 3'b000; end
      5'd2:  w_funct3 = 3'b001;
      5'd3:  w_funct3 = 3'b010;
      5'd4:  w_funct3 = 3'b011;
      5'd5:  w_funct3 = 3'b100;
      5'd6:  w_funct3 = 3'b101;
      5'd7:  begin w_funct7 = 7'h20; w_funct3 = 3'b101; end
      5'd8:  w_funct3 = 3'b110;
      5'd9:  w_funct3 = 3'b111;
      5'd10: begin w_opcode = 7'h3B; w_funct3 = 3'b000; end
      5'd11: begin w_opcode = 7'h3B; w_funct7 = 7'h20; w_funct3 = 3'b000; end
      5'd12: begin w_opcode = 7'h3B; w_funct3 = 3'b001; end
      5'd13: begin w_opcode = 7'h3B; w_funct3 = 3'b101; end
      5'd14: begin w_opcode = 7'h3B; w_funct7 = 7'h20; w_funct3 = 3'b101; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_word    = {w_funct7, rs2, rs1, w_funct3, rd, w_opcode};
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign instr     = out_valid ? r_mem[r_head] : 32'h0000_0000;
  assign err       = r_err;
  assign enc_count = r_enc_count;

  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = out_valid & out_ready;
  // Pushes only happen at count 0 or 1, so the tail is head offset by count[0].
  assign w_wr_ptr = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= 1'b0;
      r_count     <= 2'd0;
      r_err       <= 1'b0;
      r_enc_count <= 16'h0000;
    end else begin
      if (w_push) r_mem[w_wr_ptr] <= w_word;
      if (w_pop) begin
        r_head      <= ~r_head;
        r_enc_count <= r_enc_count + 16'd1;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/rtype_encoder.md
RTYPE_ENCODER -- requirements
Module: rtype_encoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  request carries a valid operation.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  5  operation select (table in REQ-012).
REQ-007 rs1, rs2, rd  input  5 each  register indices.
REQ-008 out_valid  output  1  instr holds a valid encoded word.
REQ-009 out_ready  input  1  consumer accepts instr this cycle.
REQ-010 instr  output  32  encoded RV64 R-type instruction word.
REQ-011 err, enc_count  output  1, 16  sticky illegal-op flag; count of words delivered.

Function
REQ-012 The op mapping SHALL be op -> (funct7, funct3, opcode):
- 0 ADD (0x00, 000, 0x33); 1 SUB (0x20, 000, 0x33); 2 SLL (0x00, 001, 0x33); 3 SLT (0x00, 010, 0x33); 4 SLTU (0x00, 011, 0x33).
- 5 XOR (0x00, 100, 0x33); 6 SRL (0x00, 101, 0x33); 7 SRA (0x20, 101, 0x33); 8 OR (0x00, 110, 0x33); 9 AND (0x00, 111, 0x33).
- 10 ADDW (0x00, 000, 0x3B); 11 SUBW (0x20, 000, 0x3B); 12 SLLW (0x00, 001, 0x3B); 13 SRLW (0x00, 101, 0x3B); 14 SRAW (0x20, 101, 0x3B).
- 15..31 illegal.
REQ-013 The encoded word SHALL be {funct7, rs2, rs1, funct3, rd, opcode} at bits [31:25], [24:20], [19:15], [14:12], [11:7] and [6:0].
REQ-014 A request SHALL be accepted when in_valid and in_ready are both 1 at a rising edge.
REQ-015 Legal accepted requests SHALL be encoded and pushed into a 2-entry FIFO in the same edge.
REQ-016 in_ready SHALL equal (fifo_count < 2), derived from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (fifo_count != 0); instr SHALL present the head entry, or 0 when the FIFO is empty.
REQ-018 Latency SHALL be one cycle: a word accepted at edge N is visible on instr/out_valid after edge N when the FIFO was empty.
REQ-019 While out_valid=1 and out_ready=0, instr SHALL hold stable.
REQ-020 A pop SHALL occur when out_valid and out_ready are both 1; entries SHALL leave in acceptance order.
REQ-021 Simultaneous push and pop with count=1 SHALL leave count=1, with the new word at the head on the next cycle.
REQ-022 Simultaneous push and pop with count=0 cannot occur, because out_valid=0 when the FIFO is empty.
REQ-023 A push SHALL never occur at count=2, because in_ready=0 then; count SHALL never exceed 2 or underflow.
REQ-024 An accepted illegal op SHALL be consumed, not enqueued, and SHALL set err to 1 from the next cycle until reset.
REQ-025 Illegal ops SHALL obey the same in_ready rule as legal ops.
REQ-026 enc_count SHALL increment by 1 on each pop and wrap from 0xFFFF to 0x0000.
REQ-027 rs1/rs2/rd SHALL be encoded verbatim; x0 is a legal index for every field.

Reset
REQ-028 When rst=1 at an edge, the FIFO SHALL be emptied, err and enc_count SHALL be cleared, and any in-flight push/pop that cycle SHALL be discarded.
REQ-029 During and immediately after reset: in_ready=1, out_valid=0, instr=0x00000000, err=0, enc_count=0x0000.
REQ-030 Reset asserted mid-operation with a full FIFO SHALL drop both entries; no word SHALL appear after reset deasserts unless newly accepted.

Verification
REQ-031 ADD x3,x1,x2 (op=0, rd=3, rs1=1, rs2=2) with out_ready=1 -> instr=0x002081B3, out_valid=1 one cycle later, enc_count=1.
REQ-032 SUB x3,x1,x2 then SRAW x5,x6,x7 back-to-back with out_ready=1 -> 0x402081B3 then 0x407352BB on consecutive cycles.
REQ-033 Three back-to-back requests with out_ready=0 -> in_ready drops after two accepts; raising out_ready yields the words in order; the third is accepted once space frees.
REQ-034 op=20 accepted -> nothing enqueued, out_valid stays 0, err=1 next cycle and remains 1 until rst.
REQ-035 With the FIFO full and err=1, assert rst for one cycle -> next cycle in_ready=1, out_valid=0, err=0, enc_count=0.
REQ-036 Preload enc_count to 0xFFFF via 65535 pops, then one more pop -> enc_count=0x0000.
